tag_alloc_controller: RTL and testbench
=======================================

// Module: tag_alloc_controller
// PURPOSE
//  Sequences allocator_tag_map for one AXI read port: accepts upstream AR, obtains a unique ID (UID) via alloc,
//  issues AR downstream with the UID, restores the original ID on R beats, and frees the UID on each RLAST.
//  Sits between the master-side AXI AR/R channels and the slave side; the only block driving the tag map.
// PARAMETERS
//  ID_WIDTH      4   original AXI ID width (ARID/RID upstream)
//  UID_W         4   unique-ID width, must equal tag map ROW_W+COL_W
//  AR_PAYLOAD_W  40  opaque AR bundle (addr,len,size,burst...), passed unchanged
//  R_PAYLOAD_W   34  opaque R bundle (data,resp), passed unchanged
//  STALL_W       8   width of saturating alloc-stall counter
// PORTS
//  clk              in   1            clock
//  rst              in   1            async reset, active-low
//  up_ar_valid/ready in/out 1         upstream AR handshake
//  up_ar_id         in   ID_WIDTH     original ARID
//  up_ar_payload    in   AR_PAYLOAD_W AR bundle
//  dn_ar_valid/ready out/in 1         downstream AR handshake
//  dn_ar_id         out  UID_W        remapped ARID
//  dn_ar_payload    out  AR_PAYLOAD_W registered copy of up_ar_payload
//  dn_r_valid/ready in/out 1          downstream R handshake
//  dn_r_id          in   UID_W        RID (a UID)
//  dn_r_last        in   1            RLAST
//  dn_r_payload     in   R_PAYLOAD_W  R bundle
//  up_r_valid/ready out/in 1          upstream R handshake
//  up_r_id          out  ID_WIDTH     restored RID
//  up_r_last/payload out 1/R_PAYLOAD_W registered RLAST / R bundle
//  alloc_req, alloc_in_id out 1/ID_WIDTH  to tag map (alloc_in_id from register only)
//  alloc_gnt, alloc_uid   in  1/UID_W     from tag map, same-cycle combinational
//  free_req, free_uid     out 1/UID_W     to tag map
//  restored_id, free_ack  in  ID_WIDTH/1  from tag map
//  outstanding      out  UID_W+1      UIDs granted and not yet freed
//  stall_cycles     out  STALL_W      saturating cycles spent in ALLOC without grant, current request
//  id_mismatch      out  1            sticky: restored_id != shadow entry on a free
// BEHAVIOUR
//  Reset (rst=0, async): AR FSM=IDLE, R register empty, shadow table/outstanding/stall/id_mismatch=0;
//   outputs: up_ar_ready=1, dn_ar_valid=0, up_r_valid=0, alloc_req=0, free_req=0, dn_r_ready=1.
//   Reset mid-operation drops alloc_req/free_req immediately; tag map must be reset in the same window.
//  AR FSM {IDLE, ALLOC, SEND}:
//   IDLE: up_ar_ready=1; handshake captures id/payload -> ALLOC, stall_cycles:=0.
//   ALLOC: alloc_req=1, alloc_in_id=captured id. gnt=1: dn_ar_id:=alloc_uid, shadow[alloc_uid]:=id -> SEND.
//    gnt=0: stay, stall_cycles+=1 (saturate at 2^STALL_W-1); request held stable until granted.
//   SEND: dn_ar_valid=1, id/payload stable. dn_ar_ready=1: if up_ar_valid -> accept same cycle
//    (up_ar_ready=dn_ar_ready) -> ALLOC; else -> IDLE. up_ar_ready=0 otherwise.
//   Latency: up handshake cycle T, immediate grant -> dn_ar_valid at T+2; peak 1 AR per 2 cycles.
//  R path: one-entry pipeline register. dn_r_ready = !full || up_r_ready.
//   On dn handshake: up_r_id:=shadow[dn_r_id], last/payload/uid captured; non-last beats never free.
//   free_req=1 exactly in the cycle up_r_valid&up_r_ready&up_r_last; free_uid=captured uid.
//   Same cycle: if restored_id != shadow[free_uid] -> id_mismatch:=1 (sticky until reset). free_ack ignored.
//  outstanding: +1 on grant, -1 on free_req, both in same cycle -> unchanged; never exceeds 2^UID_W.
//  Grant and free to same row in one cycle are legal; the tag map resolves them, controller issues both.
//  Shadow entry written by grant in the same cycle as a free of that UID: write wins, check uses old value.
// TESTING
//  Reset: drive rst=0 mid-ALLOC -> alloc_req=0 same cycle, up_ar_ready=1, outstanding=0 after release.
//  AR id=3, gnt in ALLOC with uid=0x4 -> dn_ar_valid at T+2, dn_ar_id=0x4, payload unchanged, outstanding=1.
//  gnt held 0 for 5 cycles -> alloc_req high, alloc_in_id=3 stable, stall_cycles=5, dn_ar_valid=0.
//  R 4 beats RID=0x4, last on beat 4 -> up_r_id=3 all beats, one free_req pulse free_uid=0x4, outstanding 1->0.
//  up_r_ready=0 with register full -> dn_r_ready=0, no free_req until last beat accepted upstream.
//  restored_id=7 vs shadow 3 on free -> id_mismatch=1 and held; back-to-back ARs in SEND accepted without IDLE.

Source files
------------

// File: rtl/tag_alloc_controller_if.sv
// AXI read-port channel bundle (AR + R) shared by the upstream and downstream sides of the tag controller.
interface tag_alloc_controller_if #(
  parameter int ID_W         = 4,
  parameter int AR_PAYLOAD_W = 40,
  parameter int R_PAYLOAD_W  = 34
) ();
  logic                    ar_valid;
  logic                    ar_ready;
  logic [ID_W-1:0]         ar_id;
  logic [AR_PAYLOAD_W-1:0] ar_payload;
  logic                    r_valid;
  logic                    r_ready;
  logic [ID_W-1:0]         r_id;
  logic                    r_last;
  logic [R_PAYLOAD_W-1:0]  r_payload;

  modport master (
    output ar_valid, ar_id, ar_payload, r_ready,
    input  ar_ready, r_valid, r_id, r_last, r_payload
  );

  modport slave (
    input  ar_valid, ar_id, ar_payload, r_ready,
    output ar_ready, r_valid, r_id, r_last, r_payload
  );
endinterface

// File: rtl/tag_alloc_controller.sv
// Remaps upstream ARIDs to unique IDs from the tag map, restores original IDs on R beats and frees UIDs on RLAST.
module tag_alloc_controller #(
  parameter int ID_WIDTH     = 4,
  parameter int UID_W        = 4,
  parameter int AR_PAYLOAD_W = 40,
  parameter int R_PAYLOAD_W  = 34,
  parameter int STALL_W      = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  tag_alloc_controller_if.slave  up_if,
  tag_alloc_controller_if.master dn_if,
  output logic                alloc_req_o,
  output logic [ID_WIDTH-1:0] alloc_in_id_o,
  input  logic                alloc_gnt_i,
  input  logic [UID_W-1:0]    alloc_uid_i,
  output logic                free_req_o,
  output logic [UID_W-1:0]    free_uid_o,
  input  logic [ID_WIDTH-1:0] restored_id_i,
  input  logic                free_ack_i,
  output logic [UID_W:0]      outstanding_o,
  output logic [STALL_W-1:0]  stall_cycles_o,
  output logic                id_mismatch_o
);
  localparam int NUM_UID = 1 << UID_W;

  typedef enum logic [1:0] {IDLE, ALLOC, SEND} ar_state_e;

  ar_state_e                 state_q, state_d;
  logic [ID_WIDTH-1:0]       ar_id_q, ar_id_d;
  logic [AR_PAYLOAD_W-1:0]   ar_payload_q, ar_payload_d;
  logic [UID_W-1:0]          uid_q, uid_d;
  logic [STALL_W-1:0]        stall_q, stall_d;
  logic                      up_ar_ready, dn_ar_valid, alloc_req;

  logic [ID_WIDTH-1:0]       shadow_q [NUM_UID];
  logic [NUM_UID-1:0]        shadow_we;

  logic                      r_full_q, r_full_d;
  logic [ID_WIDTH-1:0]       r_id_q;
  logic [UID_W-1:0]          r_uid_q;
  logic                      r_last_q;
  logic [R_PAYLOAD_W-1:0]    r_payload_q;
  logic                      dn_r_ready, dn_r_hs, up_r_hs, free_req, grant;

  logic [UID_W:0]            outstanding_q, outstanding_d;
  logic                      id_mismatch_q, id_mismatch_d;

  // Release is confirmed by the controller itself; the tag map's acknowledge carries no extra information.
  logic unused_free_ack;
  assign unused_free_ack = free_ack_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      ar_id_q      <= '0;
      ar_payload_q <= '0;
      uid_q        <= '0;
      stall_q      <= '0;
    end else begin
      state_q      <= state_d;
      ar_id_q      <= ar_id_d;
      ar_payload_q <= ar_payload_d;
      uid_q        <= uid_d;
      stall_q      <= stall_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ar_id_d      = ar_id_q;
    ar_payload_d = ar_payload_q;
    uid_d        = uid_q;
    stall_d      = stall_q;
    up_ar_ready  = 1'b0;
    dn_ar_valid  = 1'b0;
    alloc_req    = 1'b0;
    case (state_q)
      IDLE: begin
        up_ar_ready = 1'b1;
        if (up_if.ar_valid) begin
          ar_id_d      = up_if.ar_id;
          ar_payload_d = up_if.ar_payload;
          stall_d      = '0;
          state_d      = ALLOC;
        end
      end
      ALLOC: begin
        alloc_req = 1'b1;
        if (alloc_gnt_i) begin
          uid_d   = alloc_uid_i;
          state_d = SEND;
        end else if (stall_q != '1) begin
          stall_d = stall_q + 1'b1;
        end
      end
      SEND: begin
        dn_ar_valid = 1'b1;
        // Accepting the next AR while the current one leaves keeps throughput at one AR per two cycles.
        up_ar_ready = dn_if.ar_ready;
        if (dn_if.ar_ready) begin
          if (up_if.ar_valid) begin
            ar_id_d      = up_if.ar_id;
            ar_payload_d = up_if.ar_payload;
            stall_d      = '0;
            state_d      = ALLOC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant = alloc_req && alloc_gnt_i;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_UID; gi++) begin : g_shadow_we
      assign shadow_we[gi] = grant && (alloc_uid_i == UID_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_UID; i++) shadow_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_UID; i++) begin
        if (shadow_we[i]) shadow_q[i] <= ar_id_q;
      end
    end
  end

  assign dn_r_ready = !r_full_q || up_if.r_ready;
  assign dn_r_hs    = dn_if.r_valid && dn_r_ready;
  assign up_r_hs    = r_full_q && up_if.r_ready;
  assign free_req   = up_r_hs && r_last_q;
  assign r_full_d   = dn_r_hs ? 1'b1 : (up_r_hs ? 1'b0 : r_full_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_full_q    <= 1'b0;
      r_id_q      <= '0;
      r_uid_q     <= '0;
      r_last_q    <= 1'b0;
      r_payload_q <= '0;
    end else begin
      r_full_q <= r_full_d;
      if (dn_r_hs) begin
        r_id_q      <= shadow_q[dn_if.r_id];
        r_uid_q     <= dn_if.r_id;
        r_last_q    <= dn_if.r_last;
        r_payload_q <= dn_if.r_payload;
      end
    end
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (grant && !free_req)      outstanding_d = outstanding_q + 1'b1;
    else if (!grant && free_req) outstanding_d = outstanding_q - 1'b1;
  end

  // The check reads the shadow value before any same-cycle grant overwrites it.
  assign id_mismatch_d = id_mismatch_q || (free_req && (restored_id_i != shadow_q[r_uid_q]));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
      id_mismatch_q <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      id_mismatch_q <= id_mismatch_d;
    end
  end

  assign up_if.ar_ready  = up_ar_ready;
  assign up_if.r_valid   = r_full_q;
  assign up_if.r_id      = r_id_q;
  assign up_if.r_last    = r_last_q;
  assign up_if.r_payload = r_payload_q;

  assign dn_if.ar_valid   = dn_ar_valid;
  assign dn_if.ar_id      = uid_q;
  assign dn_if.ar_payload = ar_payload_q;
  assign dn_if.r_ready    = dn_r_ready;

  assign alloc_req_o    = alloc_req;
  assign alloc_in_id_o  = ar_id_q;
  assign free_req_o     = free_req;
  assign free_uid_o     = r_uid_q;
  assign outstanding_o  = outstanding_q;
  assign stall_cycles_o = stall_q;
  assign id_mismatch_o  = id_mismatch_q;
endmodule

// File: tb/tb_tag_alloc_controller.sv
// Directed bench for tag_alloc_controller; the bench plays the tag map and both AXI neighbours.
module tb_tag_alloc_controller;
  localparam int ID_WIDTH     = 4;
  localparam int UID_W        = 4;
  localparam int AR_PAYLOAD_W = 40;
  localparam int R_PAYLOAD_W  = 34;
  localparam int STALL_W      = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                alloc_req, alloc_gnt, free_req, free_ack, id_mismatch;
  logic [ID_WIDTH-1:0] alloc_in_id, restored_id;
  logic [UID_W-1:0]    alloc_uid, free_uid;
  logic [UID_W:0]      outstanding;
  logic [STALL_W-1:0]  stall_cycles;

  int err_cnt = 0;
  int chk_cnt = 0;

  localparam logic [AR_PAYLOAD_W-1:0] P1 = 40'h12_3456_789A;
  localparam logic [AR_PAYLOAD_W-1:0] P2 = 40'hA5_0F0F_1234;

  tag_alloc_controller_if #(.ID_W(ID_WIDTH), .AR_PAYLOAD_W(AR_PAYLOAD_W), .R_PAYLOAD_W(R_PAYLOAD_W)) up_if ();
  tag_alloc_controller_if #(.ID_W(UID_W), .AR_PAYLOAD_W(AR_PAYLOAD_W), .R_PAYLOAD_W(R_PAYLOAD_W)) dn_if ();

  tag_alloc_controller #(
    .ID_WIDTH(ID_WIDTH), .UID_W(UID_W), .AR_PAYLOAD_W(AR_PAYLOAD_W),
    .R_PAYLOAD_W(R_PAYLOAD_W), .STALL_W(STALL_W)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .up_if(up_if),
    .dn_if(dn_if),
    .alloc_req_o(alloc_req),
    .alloc_in_id_o(alloc_in_id),
    .alloc_gnt_i(alloc_gnt),
    .alloc_uid_i(alloc_uid),
    .free_req_o(free_req),
    .free_uid_o(free_uid),
    .restored_id_i(restored_id),
    .free_ack_i(free_ack),
    .outstanding_o(outstanding),
    .stall_cycles_o(stall_cycles),
    .id_mismatch_o(id_mismatch)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n            = 1'b1;
    alloc_gnt        = 1'b0;
    alloc_uid        = '0;
    restored_id      = '0;
    free_ack         = 1'b0;
    up_if.ar_valid   = 1'b0;
    up_if.ar_id      = '0;
    up_if.ar_payload = '0;
    up_if.r_ready    = 1'b0;
    dn_if.ar_ready   = 1'b0;
    dn_if.r_valid    = 1'b0;
    dn_if.r_id       = '0;
    dn_if.r_last     = 1'b0;
    dn_if.r_payload  = '0;
    #2 rst_n = 1'b0;

    @(negedge clk);
    check("rst_up_ar_ready", 64'(up_if.ar_ready), 64'd1);
    check("rst_dn_ar_valid", 64'(dn_if.ar_valid), 64'd0);
    check("rst_up_r_valid", 64'(up_if.r_valid), 64'd0);
    check("rst_alloc_req", 64'(alloc_req), 64'd0);
    check("rst_free_req", 64'(free_req), 64'd0);
    check("rst_dn_r_ready", 64'(dn_if.r_ready), 64'd1);
    check("rst_outstanding", 64'(outstanding), 64'd0);
    check("rst_id_mismatch", 64'(id_mismatch), 64'd0);
    cyc();
    rst_n = 1'b1;

    // AR id=3, grant withheld for five cycles, then uid 4
    up_if.ar_valid   = 1'b1;
    up_if.ar_id      = 4'd3;
    up_if.ar_payload = P1;
    @(negedge clk);
    check("idle_up_ar_ready", 64'(up_if.ar_ready), 64'd1);
    cyc();
    up_if.ar_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_alloc_req", 64'(alloc_req), 64'd1);
      check("stall_alloc_in_id", 64'(alloc_in_id), 64'd3);
      check("stall_dn_ar_valid", 64'(dn_if.ar_valid), 64'd0);
      check("stall_count", 64'(stall_cycles), 64'(i));
      cyc();
    end
    alloc_gnt = 1'b1;
    alloc_uid = 4'h4;
    @(negedge clk);
    check("stall_count_5", 64'(stall_cycles), 64'd5);
    cyc();
    alloc_gnt        = 1'b0;
    up_if.ar_valid   = 1'b1;
    up_if.ar_id      = 4'd5;
    up_if.ar_payload = P2;
    @(negedge clk);
    check("send_dn_ar_valid", 64'(dn_if.ar_valid), 64'd1);
    check("send_dn_ar_id", 64'(dn_if.ar_id), 64'h4);
    check("send_payload", 64'(dn_if.ar_payload), 64'(P1));
    check("send_outstanding", 64'(outstanding), 64'd1);
    check("send_up_ar_ready_blocked", 64'(up_if.ar_ready), 64'd0);
    check("send_stall_held", 64'(stall_cycles), 64'd5);
    cyc();

    // back-to-back AR accepted from SEND, immediate grant uid 9
    dn_if.ar_ready = 1'b1;
    @(negedge clk);
    check("b2b_up_ar_ready", 64'(up_if.ar_ready), 64'd1);
    cyc();
    dn_if.ar_ready = 1'b0;
    up_if.ar_valid = 1'b0;
    alloc_gnt      = 1'b1;
    alloc_uid      = 4'h9;
    @(negedge clk);
    check("b2b_alloc_req", 64'(alloc_req), 64'd1);
    check("b2b_alloc_in_id", 64'(alloc_in_id), 64'd5);
    check("b2b_stall_cleared", 64'(stall_cycles), 64'd0);
    check("b2b_dn_ar_valid_low", 64'(dn_if.ar_valid), 64'd0);
    cyc();
    alloc_gnt      = 1'b0;
    dn_if.ar_ready = 1'b1;
    @(negedge clk);
    check("b2b_dn_ar_valid", 64'(dn_if.ar_valid), 64'd1);
    check("b2b_dn_ar_id", 64'(dn_if.ar_id), 64'h9);
    check("b2b_payload", 64'(dn_if.ar_payload), 64'(P2));
    check("b2b_outstanding", 64'(outstanding), 64'd2);
    cyc();
    dn_if.ar_ready = 1'b0;
    @(negedge clk);
    check("back_idle_up_ar_ready", 64'(up_if.ar_ready), 64'd1);
    check("back_idle_dn_ar_valid", 64'(dn_if.ar_valid), 64'd0);

    // four-beat burst on uid 4, original id 3
    up_if.r_ready = 1'b1;
    restored_id   = 4'd3;
    for (int b = 0; b < 4; b++) begin
      dn_if.r_valid   = 1'b1;
      dn_if.r_id      = 4'h4;
      dn_if.r_last    = (b == 3);
      dn_if.r_payload = 34'(34'h100 + b);
      @(negedge clk);
      check("burst_dn_r_ready", 64'(dn_if.r_ready), 64'd1);
      if (b > 0) begin
        check("burst_up_r_id", 64'(up_if.r_id), 64'd3);
        check("burst_up_r_payload", 64'(up_if.r_payload), 64'(34'h100 + b - 1));
        check("burst_no_free", 64'(free_req), 64'd0);
      end
      cyc();
    end
    dn_if.r_valid = 1'b0;
    dn_if.r_last  = 1'b0;
    @(negedge clk);
    check("last_up_r_valid", 64'(up_if.r_valid), 64'd1);
    check("last_up_r_last", 64'(up_if.r_last), 64'd1);
    check("last_up_r_id", 64'(up_if.r_id), 64'd3);
    check("last_free_req", 64'(free_req), 64'd1);
    check("last_free_uid", 64'(free_uid), 64'h4);
    cyc();
    @(negedge clk);
    check("after_free_outstanding", 64'(outstanding), 64'd1);
    check("after_free_r_valid", 64'(up_if.r_valid), 64'd0);
    check("after_free_free_req", 64'(free_req), 64'd0);
    check("after_free_mismatch", 64'(id_mismatch), 64'd0);

    // single last beat on uid 9 (shadow 5) under upstream backpressure, wrong restored id
    up_if.r_ready   = 1'b0;
    dn_if.r_valid   = 1'b1;
    dn_if.r_id      = 4'h9;
    dn_if.r_last    = 1'b1;
    dn_if.r_payload = 34'h2_0000_00AB;
    cyc();
    dn_if.r_valid = 1'b0;
    dn_if.r_last  = 1'b0;
    @(negedge clk);
    check("bp_dn_r_ready", 64'(dn_if.r_ready), 64'd0);
    check("bp_up_r_valid", 64'(up_if.r_valid), 64'd1);
    check("bp_up_r_id", 64'(up_if.r_id), 64'd5);
    check("bp_free_req", 64'(free_req), 64'd0);
    cyc();
    @(negedge clk);
    check("bp_free_req_held", 64'(free_req), 64'd0);
    check("bp_payload", 64'(up_if.r_payload), 64'(34'h2_0000_00AB));
    up_if.r_ready = 1'b1;
    restored_id   = 4'd7;
    #1;
    check("bp_release_free_req", 64'(free_req), 64'd1);
    check("bp_release_free_uid", 64'(free_uid), 64'h9);
    check("bp_mismatch_pre", 64'(id_mismatch), 64'd0);
    cyc();
    up_if.r_ready = 1'b0;
    restored_id   = 4'd0;
    @(negedge clk);
    check("bp_outstanding_zero", 64'(outstanding), 64'd0);
    check("mismatch_set", 64'(id_mismatch), 64'd1);
    cyc();
    @(negedge clk);
    check("mismatch_sticky", 64'(id_mismatch), 64'd1);

    // reset asserted mid-ALLOC with one UID outstanding
    up_if.ar_valid = 1'b1;
    up_if.ar_id    = 4'd2;
    cyc();
    up_if.ar_valid = 1'b0;
    alloc_gnt      = 1'b1;
    alloc_uid      = 4'h1;
    cyc();
    alloc_gnt      = 1'b0;
    dn_if.ar_ready = 1'b1;
    up_if.ar_valid = 1'b1;
    up_if.ar_id    = 4'd3;
    cyc();
    dn_if.ar_ready = 1'b0;
    up_if.ar_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_alloc_req", 64'(alloc_req), 64'd1);
    check("pre_rst_outstanding", 64'(outstanding), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_alloc_req", 64'(alloc_req), 64'd0);
    check("mid_rst_up_ar_ready", 64'(up_if.ar_ready), 64'd1);
    check("mid_rst_outstanding", 64'(outstanding), 64'd0);
    check("mid_rst_mismatch", 64'(id_mismatch), 64'd0);
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_outstanding", 64'(outstanding), 64'd0);
    check("post_rst_alloc_req", 64'(alloc_req), 64'd0);
    check("post_rst_up_ar_ready", 64'(up_if.ar_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
